// File: rtl/acca_pkg.sv
// Shared types and constants for the pipelined quadrant-approximate MAC.
package acca_pkg;

   // Per-quadrant approximation mode.
   typedef enum logic [1:0] {
      EXACT       = 2'd0,
      TRUNC2      = 2'd1,
      TRUNCH      = 2'd2,
      TRUNCH_COMP = 2'd3
   } mode_e;

   // Position of each quadrant's 2-bit field inside the 8-bit mode word.
   // The index also encodes the operand halves: bit 1 = a high, bit 0 = b high.
   localparam int QUAD_LL = 0;
   localparam int QUAD_LH = 1;
   localparam int QUAD_HL = 2;
   localparam int QUAD_HH = 3;

   // Extract one quadrant's mode from the packed mode word.
   function automatic mode_e quad_mode(input logic [7:0] modes, input int idx);
      return mode_e'(modes[2*idx +: 2]);
   endfunction

endpackage

// File: rtl/acca_pipe_mac_if.sv
// Operand stream in, result stream out, both valid/ready.
interface acca_pipe_mac_if #(
   parameter int WIDTH = 8,
   parameter int ACC_W = 2*WIDTH+8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [7:0]       in_mode;
   logic             in_acc;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_data;

   // Operand source / result sink side.
   modport master (
      output in_valid, in_a, in_b, in_mode, in_acc, out_ready,
      input  in_ready, out_valid, out_data
   );

   // The MAC itself.
   modport slave (
      input  in_valid, in_a, in_b, in_mode, in_acc, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/acca_quad_mul.sv
// One H x H unsigned partial product with its approximation mode applied.
module acca_quad_mul
   import acca_pkg::*;
#(
   parameter int H = 4
) (
   input  logic [H-1:0]   a,
   input  logic [H-1:0]   b,
   input  mode_e          mode,
   output logic [2*H-1:0] p
);

   localparam logic [2*H-1:0] LOW2_MASK = (2*H)'(3);
   localparam logic [2*H-1:0] LOWH_MASK = (2*H)'((1 << H) - 1);
   localparam logic [2*H-1:0] COMP_BIT  = (2*H)'(1) << (H - 1);

   logic [2*H-1:0] exact;

   assign exact = (2*H)'(a) * (2*H)'(b);

   // Apply the quadrant's truncation / mid-point compensation.
   always_comb begin
      // NOTE: default assignment first so every path drives p and no latch is inferred.
      p = exact;
      case (mode)
         EXACT:       p = exact;
         TRUNC2:      p = exact & ~LOW2_MASK;
         TRUNCH:      p = exact & ~LOWH_MASK;
         TRUNCH_COMP: p = (exact & ~LOWH_MASK) | COMP_BIT;
         default:     p = exact;
      endcase
   end

endmodule

// File: rtl/acca_pipe_mac.sv
// Two-stage valid/ready quadrant-approximate multiply-accumulate.
// Stage 1 holds the four modified partial products; stage 2 holds the
// saturated, optionally accumulated result, which also feeds accumulation.
module acca_pipe_mac
   import acca_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int ACC_W = 2*WIDTH+8
) (
   input  logic          clk,
   input  logic          rst,
   acca_pipe_mac_if.slave bus
);

   localparam int H  = WIDTH / 2;
   localparam int PW = 2*WIDTH + 2;

   logic [H-1:0] a_hi, a_lo, b_hi, b_lo;

   logic [3:0][2*H-1:0] pp;
   logic [3:0][2*H-1:0] s1_pp;
   logic                s1_valid;
   logic                s1_acc;

   logic                s1_load;
   logic                s2_load;
   logic                out_valid;
   logic [ACC_W-1:0]    out_data;

   logic [PW-1:0]       sum_wide;
   logic [2*WIDTH-1:0]  prod;
   logic [ACC_W-1:0]    new_data;

   assign a_hi = bus.in_a[WIDTH-1:H];
   assign a_lo = bus.in_a[H-1:0];
   assign b_hi = bus.in_b[WIDTH-1:H];
   assign b_lo = bus.in_b[H-1:0];

   // Quadrant index bit 1 picks a's half, bit 0 picks b's half.
   for (genvar q = 0; q < 4; q++) begin : g_quad
      acca_quad_mul #(.H(H)) u_quad (
         .a    ((q >= 2)     ? a_hi : a_lo),
         .b    ((q % 2 == 1) ? b_hi : b_lo),
         .mode (quad_mode(bus.in_mode, q)),
         .p    (pp[q])
      );
   end

   // Handshake: s2 advances when it is empty or being drained; s1 frees up
   // whenever s2 takes its beat, so in_ready never looks at in_valid.
   assign s2_load      = s1_valid && (!out_valid || bus.out_ready);
   assign bus.in_ready = !s1_valid || s2_load;
   assign s1_load      = bus.in_valid && bus.in_ready;

   // Recombine the quadrants with two guard bits, then clamp to 2*WIDTH bits.
   always_comb begin
      sum_wide = (PW'(s1_pp[QUAD_HH]) << WIDTH)
               + ((PW'(s1_pp[QUAD_HL]) + PW'(s1_pp[QUAD_LH])) << H)
               + PW'(s1_pp[QUAD_LL]);
      if (sum_wide[PW-1:2*WIDTH] != '0)
         prod = '1;
      else
         prod = sum_wide[2*WIDTH-1:0];
      new_data = s1_acc ? (out_data + ACC_W'(prod)) : ACC_W'(prod);
   end

   // Stage 1 register: partial products, accumulate flag and valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: datapath registers are reset too, so no X ever reaches the adder tree.
         s1_valid <= 1'b0;
         s1_acc   <= 1'b0;
         s1_pp    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         if (s1_load) begin
            s1_valid <= 1'b1;
            s1_acc   <= bus.in_acc;
            s1_pp    <= pp;
         end else if (s2_load) begin
            s1_valid <= 1'b0;
         end
      end
   end

   // Stage 2 register: result and valid; data persists after consumption.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (s2_load) begin
         out_valid <= 1'b1;
         out_data  <= new_data;
      end else if (bus.out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign bus.out_valid = out_valid;
   assign bus.out_data  = out_data;

endmodule

// File: tb/tb_acca_pipe_mac.sv
// Randomised and directed checks of acca_pipe_mac against an arithmetic model.
module tb_acca_pipe_mac;

   localparam int WIDTH = 8;
   localparam int H     = WIDTH / 2;
   localparam int ACC_W = 2*WIDTH + 8;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   acca_pipe_mac_if #(.WIDTH(WIDTH), .ACC_W(ACC_W)) bus ();

   acca_pipe_mac #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   longint unsigned exp_q[$];
   longint unsigned model_last = 0;
   int              out_count  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One quadrant product, modified by its mode, from the arithmetic rules.
   function automatic longint unsigned quad_model(input longint unsigned x, input longint unsigned y,
                                                  input int m);
      longint unsigned p;
      longint unsigned hs;
      p  = x * y;
      hs = longint'(1) << H;
      case (m)
         1:       p = p - (p % 4);
         2:       p = p - (p % hs);
         3:       p = p - (p % hs) + hs / 2;
         default: ;
      endcase
      return p;
   endfunction

   // Saturated approximate product of two operands.
   function automatic longint unsigned prod_model(input longint unsigned a, input longint unsigned b,
                                                  input int mode);
      longint unsigned hs, ah, al, bh, bl, s, lim;
      hs  = longint'(1) << H;
      ah  = a / hs;
      al  = a % hs;
      bh  = b / hs;
      bl  = b % hs;
      s   = quad_model(ah, bh, (mode >> 6) & 3) * (longint'(1) << WIDTH)
          + (quad_model(ah, bl, (mode >> 4) & 3) + quad_model(al, bh, (mode >> 2) & 3)) * hs
          + quad_model(al, bl, mode & 3);
      lim = longint'(1) << (2*WIDTH);
      if (s >= lim) s = lim - 1;
      return s;
   endfunction

   // Scoreboard: transfers are decided at the next rising edge, so the
   // mid-cycle view of valid/ready tells exactly which beats move.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) check("spurious_result", 1, 0);
            else                   check("result", bus.out_data, exp_q.pop_front());
            out_count++;
         end
         if (bus.in_valid && bus.in_ready) begin
            longint unsigned p;
            p = prod_model(bus.in_a, bus.in_b, bus.in_mode);
            if (bus.in_acc) model_last = (model_last + p) & ((longint'(1) << ACC_W) - 1);
            else            model_last = p;
            exp_q.push_back(model_last);
         end
      end
   end

   // Present a beat (caller is just after a rising edge) and hold it until taken.
   task automatic drive_beat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [7:0] mode, input logic acc, output int waits);
      logic ok;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_mode  = mode;
      bus.in_acc   = acc;
      bus.in_valid = 1'b1;
      waits = 0;
      ok    = 1'b0;
      while (!ok && waits < 1000) begin
         @(negedge clk);
         ok = bus.in_ready;
         if (!ok) waits++;
      end
      if (!ok) check("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   // Single beat into an idle pipe with out_ready high: check latency and value.
   task automatic directed(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [7:0] mode, input logic acc, input logic [ACC_W-1:0] exp);
      int w;
      drive_beat(a, b, mode, acc, w);
      @(negedge clk);
      check({tag, "_not_early"}, bus.out_valid, 0);
      @(negedge clk);
      check({tag, "_valid"}, bus.out_valid, 1);
      check({tag, "_data"}, bus.out_data, exp);
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.out_valid) && n < 1000) begin
         @(posedge clk);
         n++;
      end
      #1;
      check({tag, "_drained"}, exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, stalls, oc0;
      logic [ACC_W-1:0] hold;
      time t0;

      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_a     = '0;
      bus.in_b     = '0;
      bus.in_mode  = '0;
      bus.in_acc   = 1'b0;
      bus.out_ready = 1'b1;
      #23;
      rst = 1'b0;
      @(negedge clk);
      check("reset_in_ready",  bus.in_ready,  1);
      check("reset_out_valid", bus.out_valid, 0);
      check("reset_out_data",  bus.out_data,  0);
      @(posedge clk);
      #1;

      // Exact, truncated, and saturating full-scale products.
      directed("ff_exact",  8'hFF, 8'hFF, 8'h00, 1'b0, 24'h00FE01);
      directed("ff_trunc2", 8'hFF, 8'hFF, 8'h55, 1'b0, 24'h00FCE0);
      directed("ff_comp",   8'hFF, 8'hFF, 8'hFF, 1'b0, 24'h00FFFF);
      // Accumulation chain and restart.
      directed("acc_start", 8'd3, 8'd5, 8'h00, 1'b0, 24'd15);
      directed("acc_add",   8'd2, 8'd2, 8'h00, 1'b1, 24'd19);
      directed("acc_fresh", 8'd1, 8'd1, 8'h00, 1'b0, 24'd1);

      // Backpressure: two beats fill the pipe, the third must wait.
      oc0 = out_count;
      bus.out_ready = 1'b0;
      drive_beat(8'd17, 8'd200, 8'h1B, 1'b0, w);
      drive_beat(8'd99, 8'd45,  8'hE4, 1'b1, w);
      bus.in_a     = 8'd250;
      bus.in_b     = 8'd7;
      bus.in_mode  = 8'h93;
      bus.in_acc   = 1'b1;
      bus.in_valid = 1'b1;
      @(negedge clk);
      hold = bus.out_data;
      check("bp_first_result", hold, exp_q[0]);
      for (int i = 0; i < 3; i++) begin
         check("bp_in_ready_low", bus.in_ready,  0);
         check("bp_out_valid",    bus.out_valid, 1);
         check("bp_data_stable",  bus.out_data,  hold);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      drive_beat(8'd250, 8'd7, 8'h93, 1'b1, w);
      drain("bp");
      check("bp_result_count", out_count - oc0, 3);

      // Full-rate random stream.
      oc0    = out_count;
      stalls = 0;
      t0     = $time;
      for (int i = 0; i < 100; i++) begin
         drive_beat(WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), w);
         stalls += w;
      end
      check("stream_stalls", stalls, 0);
      check("stream_cycles", ($time - t0) / 10, 100);
      drain("stream");
      check("stream_result_count", out_count - oc0, 100);

      // Asynchronous reset with both stages full.
      bus.out_ready = 1'b0;
      drive_beat(8'd201, 8'd77, 8'h00, 1'b0, w);
      drive_beat(8'd13,  8'd66, 8'h00, 1'b1, w);
      #2;
      rst = 1'b1;
      exp_q.delete();
      model_last = 0;
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data",  bus.out_data,  0);
      check("rst_in_ready",  bus.in_ready,  1);
      @(posedge clk);
      #3;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      directed("post_rst_acc", 8'd3, 8'd5, 8'h00, 1'b1, 24'd15);
      drain("final");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
